// File: rtl/block_draw_arbiter.sv
// Round-robin arbiter that shares one VGA plot port among three block-drawing requesters.
// Each granted block is streamed pixel by pixel, with off-screen pixels suppressed.
module block_draw_arbiter #(
    parameter int BLK   = 8,
    parameter int SCR_W = 320,
    parameter int SCR_H = 240
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [26:0] req_x,
    input  logic [23:0] req_y,
    input  logic [8:0]  req_color,
    output logic [2:0]  grant,
    output logic [2:0]  done,
    output logic        busy,
    output logic [8:0]  vga_x,
    output logic [7:0]  vga_y,
    output logic [2:0]  vga_color,
    output logic        plot
);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    localparam logic [3:0] D_LAST = 4'(BLK - 1);
    localparam logic [9:0] W_LIM  = 10'(SCR_W);
    localparam logic [8:0] H_LIM  = 9'(SCR_H);

    state_t      state, next_state;
    logic [1:0]  last, winner;
    logic [8:0]  bx, pix_x, hold_x, sel_x;
    logic [7:0]  by, pix_y, hold_y, sel_y;
    logic [2:0]  bc, sel_c;
    logic [3:0]  dx, dy;
    logic        row_end;

    // Search starts one past the previous winner and wraps, so last itself has lowest priority.
    always_comb begin
        winner = 2'd0;
        case (last)
            2'd0:    winner = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    winner = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: winner = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_comb begin
        sel_x = req_x[8:0];
        sel_y = req_y[7:0];
        sel_c = req_color[2:0];
        case (winner)
            2'd1: begin
                sel_x = req_x[17:9];
                sel_y = req_y[15:8];
                sel_c = req_color[5:3];
            end
            2'd2: begin
                sel_x = req_x[26:18];
                sel_y = req_y[23:16];
                sel_c = req_color[8:6];
            end
            default: ;
        endcase
    end

    assign row_end = (dx == D_LAST);
    assign pix_x   = bx + {5'b0, dx};
    assign pix_y   = by + {4'b0, dy};

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 3'b000;
        plot       = 1'b0;
        vga_color  = 3'b000;
        vga_x      = hold_x;
        vga_y      = hold_y;
        case (state)
            IDLE: begin
                if (|req) next_state = DRAW;
            end
            DRAW: begin
                busy      = 1'b1;
                vga_x     = pix_x;
                vga_y     = pix_y;
                vga_color = bc;
                plot      = ({1'b0, pix_x} < W_LIM) && ({1'b0, pix_y} < H_LIM);
                if (row_end && dy == D_LAST) next_state = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = grant;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // hold_x/hold_y keep the last emitted pixel so vga_x/vga_y stay stable between blocks.
    always_ff @(posedge clock) begin
        if (reset) begin
            grant  <= 3'b000;
            last   <= 2'd2;
            bx     <= '0;
            by     <= '0;
            bc     <= '0;
            dx     <= '0;
            dy     <= '0;
            hold_x <= '0;
            hold_y <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        bx    <= sel_x;
                        by    <= sel_y;
                        bc    <= sel_c;
                        grant <= 3'b001 << winner;
                        dx    <= '0;
                        dy    <= '0;
                    end
                end
                DRAW: begin
                    hold_x <= pix_x;
                    hold_y <= pix_y;
                    if (row_end) begin
                        dx <= '0;
                        dy <= (dy == D_LAST) ? 4'd0 : dy + 4'd1;
                    end else begin
                        dx <= dx + 4'd1;
                    end
                end
                DONE: begin
                    grant <= 3'b000;
                    last  <= grant[1] ? 2'd1 : (grant[2] ? 2'd2 : 2'd0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_block_draw_arbiter.sv
// Directed, table-driven bench for block_draw_arbiter: arbitration order, pixel stream,
// clipping, coordinate wrap, latching and mid-block reset.
module tb_block_draw_arbiter;

    localparam int BLK = 8;

    typedef struct {
        logic [2:0] req;
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] c;
        int         win;
        int         plots;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [26:0] req_x;
    logic [23:0] req_y;
    logic [8:0]  req_color;
    logic [2:0]  grant, done;
    logic        busy, plot;
    logic [8:0]  vga_x;
    logic [7:0]  vga_y;
    logic [2:0]  vga_color;

    int n_vec = 0;
    int n_bad = 0;
    vec_t vecs[10];

    always #5 clock = ~clock;

    block_draw_arbiter #(.BLK(BLK), .SCR_W(320), .SCR_H(240)) dut (
        .clock(clock), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y),
        .req_color(req_color), .grant(grant), .done(done), .busy(busy),
        .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color), .plot(plot)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_slot(input int i, input logic [8:0] x, input logic [7:0] y, input logic [2:0] c);
        req_x[9*i +: 9]     = x;
        req_y[8*i +: 8]     = y;
        req_color[3*i +: 3] = c;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_grant"}, grant, 0);
        check_output({tag, "_done"}, done, 0);
        check_output({tag, "_busy"}, busy, 0);
        check_output({tag, "_plot"}, plot, 0);
        check_output({tag, "_vga_x"}, vga_x, 0);
        check_output({tag, "_vga_y"}, vga_y, 0);
        check_output({tag, "_vga_color"}, vga_color, 0);
    endtask

    // Called #1 after an edge; drives the request and follows the whole block through DONE.
    task automatic apply_stimulus(input vec_t v, input int exp_wait);
        int         waited = 0;
        int         plots  = 0;
        logic [8:0] ex = '0;
        logic [7:0] ey = '0;
        logic       ep;
        logic [2:0] exp_grant;
        exp_grant = 3'(1 << v.win);
        for (int i = 0; i < 3; i++) begin
            if (i == v.win) set_slot(i, v.x, v.y, v.c);
            else            set_slot(i, ~v.x, ~v.y, ~v.c);
        end
        req = v.req;
        do begin
            @(posedge clock); #1;
            waited++;
            if (grant == 3'b000) check_output("idle_busy", busy, 0);
        end while (grant == 3'b000 && waited < 8);
        check_output("grant_wait", waited, exp_wait);
        check_output("grant", grant, exp_grant);
        if (grant == 3'b000) return;
        set_slot(v.win, v.x + 9'd37, v.y + 8'd11, v.c ^ 3'b111);
        for (int k = 0; k < BLK * BLK; k++) begin
            if (k > 0) begin
                @(posedge clock); #1;
            end
            ex = v.x + 9'(k % BLK);
            ey = v.y + 8'(k / BLK);
            ep = (ex < 9'd320) && (ey < 8'd240);
            check_output("draw_grant", grant, exp_grant);
            check_output("draw_vga_x", vga_x, ex);
            check_output("draw_vga_y", vga_y, ey);
            check_output("draw_color", vga_color, v.c);
            check_output("draw_plot", plot, ep);
            check_output("draw_done", done, 0);
            if (plot) plots++;
        end
        @(posedge clock); #1;
        check_output("done_pulse", done, exp_grant);
        check_output("done_busy", busy, 1);
        check_output("done_plot", plot, 0);
        check_output("done_color", vga_color, 0);
        check_output("done_hold_x", vga_x, ex);
        check_output("done_hold_y", vga_y, ey);
        check_output("plot_count", plots, v.plots);
    endtask

    initial begin
        vecs[0] = '{3'b001, 9'd10,  8'd20,  3'd5, 0, 64};
        vecs[1] = '{3'b111, 9'd100, 8'd50,  3'd3, 1, 64};
        vecs[2] = '{3'b111, 9'd300, 8'd200, 3'd1, 2, 64};
        vecs[3] = '{3'b111, 9'd5,   8'd5,   3'd2, 0, 64};
        vecs[4] = '{3'b111, 9'd319, 8'd239, 3'd4, 1, 1};
        vecs[5] = '{3'b001, 9'd316, 8'd236, 3'd6, 0, 16};
        vecs[6] = '{3'b010, 9'd508, 8'd100, 3'd3, 1, 32};
        vecs[7] = '{3'b110, 9'd0,   8'd0,   3'd7, 2, 64};
        vecs[8] = '{3'b011, 9'd312, 8'd232, 3'd6, 0, 64};
        vecs[9] = '{3'b101, 9'd200, 8'd250, 3'd5, 2, 16};

        reset     = 1'b1;
        req       = 3'b000;
        req_x     = '0;
        req_y     = '0;
        req_color = '0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            apply_stimulus(vecs[i], (i == 0) ? 1 : 2);
        end

        // Abort a block at pixel 30 with reset; nothing may complete afterwards.
        req = 3'b000;
        @(posedge clock); #1;
        set_slot(0, 9'd40, 8'd40, 3'd6);
        req = 3'b001;
        @(posedge clock); #1;
        check_output("abort_grant", grant, 3'b001);
        repeat (30) @(posedge clock);
        #1;
        check_output("abort_px30_x", vga_x, 9'd46);
        check_output("abort_px30_y", vga_y, 8'd43);
        reset = 1'b1;
        req   = 3'b000;
        @(posedge clock); #1;
        check_reset_outputs("abort");
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            check_output("abort_no_done", done, 0);
            check_output("abort_idle", busy, 0);
        end

        apply_stimulus('{3'b100, 9'd60, 8'd70, 3'd2, 2, 64}, 1);
        apply_stimulus('{3'b011, 9'd0, 8'd239, 3'd1, 0, 8}, 2);
        req = 3'b000;
        @(posedge clock); #1;
        check_output("final_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/block_draw_arbiter.md
# block_draw_arbiter

Shares the single VGA adapter plot port among three block-drawing requesters (maze renderer, player sprite, PS2 cursor). Each requester asks for one solid-colour BLK×BLK block at a pixel origin. The arbiter grants requesters round-robin, latches the request, and sequences the block pixel by pixel onto the adapter's x/y/colour/plot inputs. Off-screen pixels are suppressed, and completion is signalled back to the requester.

## Interface
- BLK, 8: block edge in pixels; legal range 1–16. The block is BLK×BLK pixels.
- SCR_W, 320: visible width; pixels with x ≥ SCR_W are not plotted.
- SCR_H, 240: visible height; pixels with y ≥ SCR_H are not plotted.

- clock  in  1  system clock (CLOCK_50). Single clock domain.
- reset  in  1  synchronous, active-high reset.
- req  in  3  request per requester; bit i belongs to requester i.
- req_x  in  27  origin x per requester; requester i uses bits [9i+8:9i].
- req_y  in  24  origin y per requester; requester i uses bits [8i+7:8i].
- req_color  in  9  colour per requester; requester i uses bits [3i+2:3i].
- grant  out  3  one-hot; high while requester i's block is being drawn.
- done  out  3  one-cycle completion pulse to the granted requester.
- busy  out  1  high in DRAW and DONE.
- vga_x  out  9  pixel x to the adapter.
- vga_y  out  8  pixel y to the adapter.
- vga_color  out  3  pixel colour to the adapter.
- plot  out  1  write strobe to the adapter.

## Operation
- States:
  - IDLE: no block in progress; arbitrates each cycle.
  - DRAW: emits one pixel per cycle.
  - DONE: single cycle that pulses done.
- IDLE: if req ≠ 0, select the first set bit searching from (last+1) mod 3 upward, wrapping.
  - On that edge: latch the winner's x, y and colour into bx, by, bc; set grant; clear dx and dy; go to DRAW.
  - last resets to 2, so requester 0 wins first after reset.
- Request inputs are sampled only on the grant edge. The requester may change req_x/req_y/req_color afterwards.
- DRAW: dx increments every cycle.
  - When dx = BLK-1: dx ← 0 and dy increments.
  - When dx = dy = BLK-1: go to DONE.
- DRAW outputs, combinational from registers:
  - vga_x = bx + dx, 9-bit, wraps mod 512.
  - vga_y = by + dy, 8-bit, wraps mod 256.
  - vga_color = bc.
  - plot = (vga_x < SCR_W) && (vga_y < SCR_H).
- Clipped pixels still consume their cycle. Block duration is always BLK² cycles.
- DONE: done[i] = 1 for the granted i; grant ← 0; last ← i; go to IDLE.
- Requester protocol: hold req[i] until done[i]. Then drop it in the cycle after done, or it is re-arbitrated as a new request.
- Requests arriving during DRAW or DONE wait; a request is never lost while held.
- Outside DRAW: plot = 0, vga_color = 0. vga_x and vga_y hold their last value, or 0 after reset.

## Timing
- Reset values: state IDLE; grant 0; done 0; busy 0; plot 0; vga_x 0; vga_y 0; vga_color 0; dx = dy = 0; last = 2.
- Request visible in IDLE at edge t: grant and first pixel (dx = dy = 0) valid in cycle t+1.
- Pixel k (k = dy·BLK + dx) appears in cycle t+1+k.
- done pulses in cycle t+1+BLK².
- IDLE again in cycle t+2+BLK²; the earliest next grant is that cycle's edge.
- Block period with back-to-back requests: BLK²+2 cycles (66 for BLK = 8).
- Reset asserted mid-DRAW: the next cycle shows all outputs at reset values. No done pulse; the aborted block is dropped, and its requester must re-request.
- Simultaneous requests: exactly one grant, by rotating priority; never two bits of grant or done set.

## Test plan
- Reset, then req = 001, x = 10, y = 20, colour = 5:
  - grant = 001 next cycle.
  - 64 plot cycles covering (10..17, 20..27) in row-major order, colour 5.
  - done[0] pulses in cycle 65; busy low after it.
- req = 111 held continuously:
  - grants in order 0, 1, 2, 0.
  - each block is 64 pixels; grants 66 cycles apart; never two grants at once.
- Clipping, x = 316, y = 236:
  - plot high only for x 316–319 and y 236–239 (16 pixels).
  - done still at cycle 65.
- Wrap, x = 508:
  - vga_x sequence 508..511, 0..3.
  - plot high for x 0–3 only (y in range).
- Reset asserted at pixel 30 of a block:
  - next cycle all outputs 0; no done pulse.
  - a subsequent req = 100 draws normally; after that grant, requester 0 is searched first.
- Coordinates changed one cycle after grant: drawn block still uses the latched origin and colour.
